// File: rtl/w_clk_module_sync.sv
// Write-side pointer and flag controller of the asynchronous FIFO (w_clk domain).
// Keeps the binary/Gray write pointers, synchronizes the Gray read pointer and registers the status flags.
module w_clk_module_sync #(
  parameter int ADDRESS_SIZE = 2,
  parameter int AF_MARGIN    = 1
) (
  input  logic                    w_clk,
  input  logic                    wrst,
  input  logic                    w_en,
  input  logic                    w_ovf_clr,
  input  logic [ADDRESS_SIZE:0]   r_ptr,
  output logic [ADDRESS_SIZE:0]   w_ptr,
  output logic [ADDRESS_SIZE-1:0] w_addr,
  output logic                    w_wen,
  output logic                    w_full,
  output logic                    w_almost_full,
  output logic [ADDRESS_SIZE:0]   w_level,
  output logic                    w_overflow
);

  localparam int DEPTH = 2 ** ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0] PTR_ONE   = (ADDRESS_SIZE + 1)'(1);
  localparam logic [ADDRESS_SIZE:0] AF_THRESH = (ADDRESS_SIZE + 1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDRESS_SIZE:0] PTR_ONES  = '1;
  // Inverting the two MSBs of a Gray read pointer yields the write pointer one lap ahead.
  localparam logic [ADDRESS_SIZE:0] FULL_MASK = ~(PTR_ONES >> 2);

  logic [ADDRESS_SIZE:0] r_bin;
  logic [ADDRESS_SIZE:0] r_gptr;
  logic [ADDRESS_SIZE:0] r_rq1;
  logic [ADDRESS_SIZE:0] r_rq2;
  logic                  r_full;
  logic                  r_af;
  logic [ADDRESS_SIZE:0] r_level;
  logic                  r_ovf;

  logic [ADDRESS_SIZE:0] w_bnext;
  logic [ADDRESS_SIZE:0] w_gnext;
  logic [ADDRESS_SIZE:0] w_rbin_sync;
  logic [ADDRESS_SIZE:0] w_diff;
  logic                  w_accept;

  assign w_accept = w_en & ~r_full & ~wrst;
  assign w_bnext  = w_accept ? (r_bin + PTR_ONE) : r_bin;
  assign w_gnext  = w_bnext ^ (w_bnext >> 1);
  assign w_diff   = w_bnext - w_rbin_sync;

  always_comb begin
    w_rbin_sync = '0;
    for (int i = 0; i <= ADDRESS_SIZE; i++) begin
      w_rbin_sync[i] = ^(r_rq2 >> i);
    end
  end

  always_ff @(posedge w_clk) begin
    if (wrst) begin
      r_bin   <= '0;
      r_gptr  <= '0;
      r_rq1   <= '0;
      r_rq2   <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bnext;
      r_gptr  <= w_gnext;
      r_rq1   <= r_ptr;
      r_rq2   <= r_rq1;
      r_full  <= (w_gnext == (r_rq2 ^ FULL_MASK));
      r_af    <= (w_diff >= AF_THRESH);
      r_level <= w_diff;
      // A new overflow on the same edge as a clear keeps the flag set.
      r_ovf   <= (w_en & r_full) | (r_ovf & ~w_ovf_clr);
    end
  end

  assign w_wen         = w_accept;
  assign w_ptr         = r_gptr;
  assign w_addr        = r_bin[ADDRESS_SIZE-1:0];
  assign w_full        = r_full;
  assign w_almost_full = r_af;
  assign w_level       = r_level;
  assign w_overflow    = r_ovf;

endmodule

// File: doc/w_clk_module_sync.md
Name: w_clk_module_sync

Overview:
- Write-side pointer and flag controller for the asynchronous FIFO. It is the counterpart of the read-side controller.
- Runs entirely in the w_clk domain.
- Maintains the binary write address and the Gray write pointer exported to the read domain. Synchronizes the Gray read pointer into w_clk.
- Generates the registered full, almost-full, fill-level and sticky overflow flags, plus the memory write strobe.

Parameters:
- ADDRESS_SIZE, 2, memory address width; DEPTH = 2**ADDRESS_SIZE; legal range ≥ 1.
- AF_MARGIN, 1, almost-full asserts when level ≥ DEPTH − AF_MARGIN; legal range 1..DEPTH.

Ports:
- w_clk  input  1  write clock.
- wrst  input  1  synchronous, active-high reset.
- w_en  input  1  write request.
- w_ovf_clr  input  1  clears the sticky overflow flag.
- r_ptr  input  ADDRESS_SIZE+1  Gray read pointer from the read domain (asynchronous).
- w_ptr  output  ADDRESS_SIZE+1  registered Gray write pointer, sent to the read domain.
- w_addr  output  ADDRESS_SIZE  memory write address = w_bin[ADDRESS_SIZE-1:0].
- w_wen  output  1  memory write strobe (combinational).
- w_full  output  1  registered full flag.
- w_almost_full  output  1  registered almost-full flag.
- w_level  output  ADDRESS_SIZE+1  registered fill level, 0..DEPTH.
- w_overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset
  - wrst is sampled only at posedge w_clk.
  - It clears w_bin, w_ptr, both synchronizer stages, w_full, w_almost_full, w_level and w_overflow to 0.
  - While wrst=1, w_wen=0 and w_en is ignored.
  - A reset in mid-stream discards all pointer state at that edge; the read side must be reset as well.
- Write accept
  - w_wen = w_en & !w_full & !wrst.
  - w_bnext = w_wen ? w_bin+1 : w_bin, computed modulo 2**(ADDRESS_SIZE+1), with natural wrap.
  - w_gnext = w_bnext ^ (w_bnext >> 1).
  - On each edge: w_bin <= w_bnext and w_ptr <= w_gnext.
  - The memory writes at w_addr on the same edge that w_wen=1. The pointer therefore leads the stored data by 0 cycles.
- Synchronizer
  - Two-stage flop chain rq2_rptr <= rq1 <= r_ptr, reset to 0 by wrst.
  - A change on r_ptr is visible in rq2_rptr after 2 edges.
- Full
  - w_full <= (w_gnext == {~rq2_rptr[ADDRESS_SIZE:ADDRESS_SIZE-1], rq2_rptr[ADDRESS_SIZE-2:0]}).
  - For ADDRESS_SIZE=1, both bits are inverted.
  - w_full asserts on the same edge as the write that fills the last entry, so there is no extra write window.
  - Deassertion is pessimistic: it happens 3 edges after r_ptr advances (2 sync + 1 flag register).
- Level
  - rbin_sync = Gray-to-binary of rq2_rptr.
  - w_level <= w_bnext − rbin_sync, modulo 2**(ADDRESS_SIZE+1).
  - The result is never > DEPTH under legal operation.
- Almost-full
  - w_almost_full <= ((w_bnext − rbin_sync) ≥ DEPTH − AF_MARGIN).
  - Whenever w_full=1, w_almost_full=1.
- Overflow
  - w_overflow <= (w_en & w_full) | (w_overflow & !w_ovf_clr).
  - If a set and a clear occur on the same edge, set wins.
  - A rejected write leaves w_bin, w_ptr and memory unchanged.
- Simultaneous write and read-pointer change
  - Flags are computed from the rq2_rptr value at that edge.
  - The read change takes effect in the flags later, per the synchronizer latency.

Test Plan (ADDRESS_SIZE=2, AF_MARGIN=1, r_ptr held at 3'b000 unless stated):
- Reset with w_en=1: hold wrst=1 for 2 edges -> w_ptr=000, w_addr=0, w_wen=0, w_full=0, w_almost_full=0, w_level=0, w_overflow=0.
- Fill: 4 consecutive w_en cycles ->
  - w_addr = 0,1,2,3.
  - w_ptr after each edge = 001, 011, 010, 110.
  - w_almost_full=1 after the 3rd edge (level 3).
  - w_full=1 and w_level=4 after the 4th edge.
- Overflow: w_en=1 for 2 cycles while full ->
  - w_wen=0 and w_ptr stays 110.
  - w_overflow=1 after the first edge and stays 1.
  - Pulsing w_ovf_clr with w_en=0 clears it.
  - Clear and attempt on the same edge -> w_overflow stays 1.
- Release: r_ptr 000->001 while full -> w_full=0 and w_level=3 on the 3rd edge after the change; w_almost_full stays 1.
- Wrap:
  - Interleave so that 8 writes complete, with r_ptr tracking the reads.
  - Expect the w_ptr sequence to pass 110 (bin 4, MSB set).
  - After the 8th write, w_ptr returns to 000.
  - w_full asserts only when the level reaches 4, including across the wrap.
- Mid-operation reset: wrst=1 at level 2 -> on the next edge all outputs and the synchronizer are 0; the first write after release uses w_addr=0.
